// File: rtl/approx_adder_err_monitor.sv
// Streaming error-metric monitor for approximate W-bit adders: per-window sum, max and count of |exact - approx|.
// Optional worst-case sample capture is enabled by defining ERR_MON_WCE_CAPTURE_EN.
module approx_adder_err_monitor #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned ACC_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [W:0]       approx_out,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [W:0]       max_abs_err,
    output logic [CNT_W-1:0] err_count,
    output logic             sum_sat
`ifdef ERR_MON_WCE_CAPTURE_EN
    ,
    output logic [W-1:0]     wce_in1,
    output logic [W-1:0]     wce_in2,
    output logic [W:0]       wce_approx
`endif
);

    localparam int unsigned EW     = W + 1;
    localparam int unsigned SW     = W + 2;
    localparam int unsigned SUMX_W = ACC_W + 1;
    localparam logic [1:0]  DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [1:0]       r_drain;

    logic             r_s1_valid;
    logic [W:0]       r_s1_exact;
    logic [W:0]       r_s1_approx;
    logic             r_s2_valid;
    logic [W:0]       r_s2_abs;

    logic [ACC_W-1:0] r_sum;
    logic [W:0]       r_max;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic             w_accept;
    logic             w_start_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic signed [SW-1:0] w_diff;
    logic [W:0]       w_abs;
    logic [SUMX_W-1:0] w_sum_ext;

    assign w_accept   = in_valid && r_in_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cnt_inc  = r_acc_cnt + CNT_W'(1);

    // Signed difference is wide enough for both signs; |diff| always fits W+1 bits.
    assign w_diff    = $signed({1'b0, r_s1_exact}) - $signed({1'b0, r_s1_approx});
    assign w_abs     = w_diff[SW-1] ? EW'(-w_diff) : EW'(w_diff);
    assign w_sum_ext = SUMX_W'(r_sum) + SUMX_W'(r_s2_abs);

    // Window control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_num      <= '0;
            r_acc_cnt  <= '0;
            r_drain    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num     <= num_samples;
                        r_acc_cnt <= '0;
                        r_drain   <= '0;
                        if (num_samples == '0) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_num) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                            r_drain    <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Flush both pipeline stages and the statistics update before signalling done.
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ERR_MON_WCE_CAPTURE_EN
    logic [W-1:0] r_s1_in1;
    logic [W-1:0] r_s1_in2;
    logic [W-1:0] r_s2_in1;
    logic [W-1:0] r_s2_in2;
    logic [W:0]   r_s2_approx;
    logic [W-1:0] r_wce_in1;
    logic [W-1:0] r_wce_in2;
    logic [W:0]   r_wce_approx;

    // Operand side-band travelling with the sample, and the captured worst-case sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_in1     <= '0;
            r_s1_in2     <= '0;
            r_s2_in1     <= '0;
            r_s2_in2     <= '0;
            r_s2_approx  <= '0;
            r_wce_in1    <= '0;
            r_wce_in2    <= '0;
            r_wce_approx <= '0;
        end else begin
            if (w_accept) begin
                r_s1_in1 <= in1;
                r_s1_in2 <= in2;
            end
            if (r_s1_valid) begin
                r_s2_in1    <= r_s1_in1;
                r_s2_in2    <= r_s1_in2;
                r_s2_approx <= r_s1_approx;
            end
            if (w_start_ok) begin
                r_wce_in1    <= '0;
                r_wce_in2    <= '0;
                r_wce_approx <= '0;
            end else if (r_s2_valid && (r_s2_abs > r_max)) begin
                r_wce_in1    <= r_s2_in1;
                r_wce_in2    <= r_s2_in2;
                r_wce_approx <= r_s2_approx;
            end
        end
    end

    assign wce_in1    = r_wce_in1;
    assign wce_in2    = r_wce_in2;
    assign wce_approx = r_wce_approx;
`endif

    // Two-stage error pipeline followed by the statistics accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_abs    <= '0;
            r_sum       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_exact  <= EW'(in1) + EW'(in2);
                r_s1_approx <= approx_out;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_abs <= w_abs;
            end
            if (w_start_ok) begin
                r_sum <= '0;
                r_max <= '0;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (r_s2_valid) begin
                if (w_sum_ext[ACC_W]) begin
                    r_sum <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_sum <= w_sum_ext[ACC_W-1:0];
                end
                if (r_s2_abs > r_max) begin
                    r_max <= r_s2_abs;
                end
                if (r_s2_abs != '0) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sum_abs_err = r_sum;
    assign max_abs_err = r_max;
    assign err_count   = r_cnt;
    assign sum_sat     = r_sat;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Self-checking bench for approx_adder_err_monitor: a default-width instance and a narrow-accumulator
// instance share stimulus; per-window expectations are queued by a reference model and checked at done.
module tb_approx_adder_err_monitor;

    localparam int unsigned W     = 8;
    localparam int unsigned EW    = W + 1;
    localparam int unsigned CNT_W = 17;
    localparam int unsigned ACC_W = 26;
    localparam int unsigned ACC_N = 10;
    localparam longint      MAX_A = (64'd1 << ACC_W) - 1;
    localparam longint      MAX_B = (64'd1 << ACC_N) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic [W-1:0]     in1;
    logic [W-1:0]     in2;
    logic [W:0]       approx_out;

    logic             in_ready_a, busy_a, done_a, sat_a;
    logic [ACC_W-1:0] sum_a;
    logic [W:0]       max_a;
    logic [CNT_W-1:0] cnt_a;
    logic             in_ready_b, busy_b, done_b, sat_b;
    logic [ACC_N-1:0] sum_b;
    logic [W:0]       max_b;
    logic [CNT_W-1:0] cnt_b;
`ifdef ERR_MON_WCE_CAPTURE_EN
    logic [W-1:0]     wce1_a, wce2_a, wce1_b, wce2_b;
    logic [W:0]       wcea_a, wcea_b;
`endif

    approx_adder_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_a), .in1(in1), .in2(in2),
        .approx_out(approx_out), .busy(busy_a), .done(done_a),
        .sum_abs_err(sum_a), .max_abs_err(max_a), .err_count(cnt_a), .sum_sat(sat_a)
`ifdef ERR_MON_WCE_CAPTURE_EN
        , .wce_in1(wce1_a), .wce_in2(wce2_a), .wce_approx(wcea_a)
`endif
    );

    approx_adder_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_N)) dut_n (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_b), .in1(in1), .in2(in2),
        .approx_out(approx_out), .busy(busy_b), .done(done_b),
        .sum_abs_err(sum_b), .max_abs_err(max_b), .err_count(cnt_b), .sum_sat(sat_b)
`ifdef ERR_MON_WCE_CAPTURE_EN
        , .wce_in1(wce1_b), .wce_in2(wce2_b), .wce_approx(wcea_b)
`endif
    );

    typedef struct {
        longint total;
        int     mx;
        int     cnt;
        int     w1;
        int     w2;
        int     wa;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   m;
    int     n_vec = 0;
    int     n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lsb3_add(input int a, input int b);
        return (((a >> 3) + (b >> 3)) << 3) | ((a | b) & 7);
    endfunction

    task automatic model_clear();
        m.total = 0; m.mx = 0; m.cnt = 0; m.w1 = 0; m.w2 = 0; m.wa = 0;
    endtask

    task automatic do_start(input int n);
        model_clear();
        num_samples = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one sample until accepted and fold it into the reference model.
    task automatic send(input int a, input int b, input int ap);
        int g;
        int ae;
        in1 = W'(a);
        in2 = W'(b);
        approx_out = EW'(ap);
        in_valid = 1'b1;
        g = 0;
        while (!in_ready_a && g < 20) begin
            tick();
            g++;
        end
        if (!in_ready_a) chk("ready_timeout", 64'(in_ready_a), 64'd1);
        tick();
        ae = (a + b) - ap;
        if (ae < 0) ae = -ae;
        ae = ae & 511;
        m.total += ae;
        if (ae != 0) m.cnt++;
        if (ae > m.mx) begin
            m.mx = ae; m.w1 = a; m.w2 = b; m.wa = ap;
        end
    endtask

    task automatic end_window();
        sb_q.push_back(m);
    endtask

    // Wait (bounded) for done, then pop the queued expectation and compare both instances.
    task automatic check_window(input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!done_a && lat < 50) begin
            tick();
            lat++;
        end
        chk("done_latency", 64'(lat), 64'(exp_lat));
        chk("done_a", 64'(done_a), 64'd1);
        chk("done_b", 64'(done_b), 64'd1);
        chk("busy_a_done", 64'(busy_a), 64'd0);
        chk("in_ready_done", 64'(in_ready_a), 64'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk("sum_a", 64'(sum_a), 64'((e.total > MAX_A) ? MAX_A : e.total));
            chk("sat_a", 64'(sat_a), 64'(e.total > MAX_A));
            chk("max_a", 64'(max_a), 64'(e.mx));
            chk("cnt_a", 64'(cnt_a), 64'(e.cnt));
            chk("sum_b", 64'(sum_b), 64'((e.total > MAX_B) ? MAX_B : e.total));
            chk("sat_b", 64'(sat_b), 64'(e.total > MAX_B));
            chk("max_b", 64'(max_b), 64'(e.mx));
            chk("cnt_b", 64'(cnt_b), 64'(e.cnt));
`ifdef ERR_MON_WCE_CAPTURE_EN
            chk("wce_in1", 64'(wce1_a), 64'(e.w1));
            chk("wce_in2", 64'(wce2_a), 64'(e.w2));
            chk("wce_approx", 64'(wcea_a), 64'(e.wa));
            chk("wce_approx_b", 64'(wcea_b), 64'(e.wa));
`endif
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in1 = '0; in2 = '0; approx_out = '0;
        model_clear();
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_sum", 64'(sum_a), 64'd0);
        chk("rst_max", 64'(max_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_sat", 64'(sat_a), 64'd0);

        // Single sample: stats visible two edges after accept, done on the third.
        do_start(1);
        chk("run_busy", 64'(busy_a), 64'd1);
        chk("run_in_ready", 64'(in_ready_a), 64'd1);
        send(3, 5, 7);
        in_valid = 1'b0;
        tick();
        chk("t1_done", 64'(done_a), 64'd0);
        tick();
        chk("t2_sum", 64'(sum_a), 64'd1);
        chk("t2_done", 64'(done_a), 64'd0);
        end_window();
        check_window(1);

        // Tie on max error with in_valid toggling: first worst case is kept.
        do_start(2);
        send(7, 7, 7);
        in_valid = 1'b0;
        tick();
        send(255, 255, 503);
        in_valid = 1'b0;
        end_window();
        check_window(3);
        chk("tie_sum_const", 64'(sum_a), 64'd14);

        // Narrow accumulator saturates; a fresh start clears the sticky flag.
        do_start(4);
        for (int i = 0; i < 4; i++) send(0, 0, 511);
        in_valid = 1'b0;
        end_window();
        check_window(3);
        chk("sat_b_const", 64'(sum_b), 64'd1023);
        do_start(0);
        end_window();
        check_window(0);

        // Exact adder with random operands and random bubbles: zero error.
        do_start(2048);
        for (int i = 0; i < 2048; i++) begin
            int a, b;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            send(a, b, a + b);
        end
        in_valid = 1'b0;
        end_window();
        check_window(3);
        chk("exact_sum_const", 64'(sum_a), 64'd0);

        // Exhaustive sweep of the 3-LSB OR-based approximate adder, back-to-back.
        do_start(65536);
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                send(a, b, lsb3_add(a, b));
            end
        end
        in_valid = 1'b0;
        end_window();
        check_window(3);
        chk("sweep_sum_const", 64'(sum_a), 64'd114688);
        chk("sweep_max_const", 64'(max_a), 64'd7);
        chk("sweep_cnt_const", 64'(cnt_a), 64'd37888);

        // Start ignored mid-window, then reset discards the window and in-flight samples.
        do_start(200);
        for (int i = 0; i < 100; i++) send(i & 255, 1, (i & 255) + 2);
        in_valid = 1'b0;
        num_samples = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_busy", 64'(busy_a), 64'd1);
        chk("start_ignored_done", 64'(done_a), 64'd0);
        chk("mid_sum", 64'(sum_a), 64'd99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("mid_rst_sum", 64'(sum_a), 64'd0);
        chk("mid_rst_max", 64'(max_a), 64'd0);
        chk("mid_rst_cnt", 64'(cnt_a), 64'd0);
        tick(); tick();
        chk("mid_rst_flushed", 64'(sum_a), 64'd0);
        do_start(0);
        end_window();
        check_window(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
